ibex_fpu_wb_arbiter: RTL and testbench

IBEX_FPU_WB_ARBITER -- requirements
Module: ibex_fpu_wb_arbiter

---
 rtl/ibex_fpu_pkg.sv | 22 ++
 rtl/ibex_fpu_scoreboard.sv | 67 ++++++
 rtl/ibex_fpu_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_ibex_fpu_wb_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ibex_fpu_pkg
// Description : Shared constants and types for the FP register-file
//               writeback arbiter and its hazard scoreboard.
//               FP_REG_ADDR_W - width of an FP register index
//               FP_NUM_REGS   - number of FP registers tracked
//               fp_wb_src_e   - identifies a writeback requester
// Revision    : 1.0 - initial release
// ============================================================================
package ibex_fpu_pkg;

  localparam int unsigned FP_REG_ADDR_W = 5;
  localparam int unsigned FP_NUM_REGS   = 32;

  typedef enum logic [0:0] {
    FP_WB_FPU = 1'b0,
    FP_WB_LSU = 1'b1
  } fp_wb_src_e;

endpackage : ibex_fpu_pkg
`default_nettype wire

// File: rtl/ibex_fpu_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : ibex_fpu_scoreboard
// Description : Pending-write tracker for the FP register file. A bit is set
//               when the decoder reserves a destination and cleared when the
//               register-file write for that index is presented. Hazard
//               outputs are pure lookups into the registered pending vector.
// Ports       : clk_i, rst_ni            - clock, async active-low reset
//               issue_valid_i/waddr_i    - destination reservation
//               flush_i                  - drop all reservations
//               wb_valid_i/wb_waddr_i    - register-file write this cycle
//               raddr_a_i/raddr_b_i      - source operand indices
//               hazard_a/b/w_o           - pending lookups (src A, src B, dest)
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_fpu_scoreboard
  import ibex_fpu_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     issue_valid_i,
  input  logic [FP_REG_ADDR_W-1:0] issue_waddr_i,
  input  logic                     flush_i,
  input  logic                     wb_valid_i,
  input  logic [FP_REG_ADDR_W-1:0] wb_waddr_i,
  input  logic [FP_REG_ADDR_W-1:0] raddr_a_i,
  input  logic [FP_REG_ADDR_W-1:0] raddr_b_i,
  output logic                     hazard_a_o,
  output logic                     hazard_b_o,
  output logic                     hazard_w_o
);

  logic [FP_NUM_REGS-1:0] r_pending;
  logic [FP_NUM_REGS-1:0] w_set;
  logic [FP_NUM_REGS-1:0] w_clr;
  logic [FP_NUM_REGS-1:0] w_pending_d;

  // Set is OR-ed in after the clear so a reservation landing on the same edge
  // as a retiring write (or a flush) survives.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (issue_valid_i) begin
      w_set[issue_waddr_i] = 1'b1;
    end
    if (flush_i) begin
      w_clr = '1;
    end else if (wb_valid_i) begin
      w_clr[wb_waddr_i] = 1'b1;
    end
    w_pending_d = (r_pending & ~w_clr) | w_set;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_d;
    end
  end

  assign hazard_a_o = r_pending[raddr_a_i];
  assign hazard_b_o = r_pending[raddr_b_i];
  assign hazard_w_o = r_pending[issue_waddr_i];

endmodule : ibex_fpu_scoreboard
`default_nettype wire

// File: rtl/ibex_fpu_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ibex_fpu_wb_arbiter
// Description : Round-robin arbiter sharing the single FP register-file write
//               port between FPU results and FP loads, with a registered
//               output stage (one write per cycle) and an optional RAW/WAW
//               hazard scoreboard.
// Config      : IBEX_FPU_SCOREBOARD_EN - when defined, instantiates
//               ibex_fpu_scoreboard; otherwise hazard outputs are tied low
//               and the issue/flush/read-address inputs are ignored.
// Ports       : clk_i, rst_ni                     - clock, async active-low reset
//               fpu_valid_i/ready_o/waddr_i/wdata_i - FPU writeback request
//               lsu_valid_i/ready_o/waddr_i/wdata_i - load writeback request
//               rf_we_o/rf_waddr_o/rf_wdata_o     - register-file write port
//               issue_valid_i/issue_waddr_i       - destination reservation
//               raddr_a_i/raddr_b_i               - hazard query indices
//               hazard_a_o/hazard_b_o/hazard_w_o  - hazard query results
//               flush_i                           - discard reservations
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_fpu_wb_arbiter
  import ibex_fpu_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,

  input  logic                     fpu_valid_i,
  output logic                     fpu_ready_o,
  input  logic [FP_REG_ADDR_W-1:0] fpu_waddr_i,
  input  logic [DataWidth-1:0]     fpu_wdata_i,

  input  logic                     lsu_valid_i,
  output logic                     lsu_ready_o,
  input  logic [FP_REG_ADDR_W-1:0] lsu_waddr_i,
  input  logic [DataWidth-1:0]     lsu_wdata_i,

  output logic                     rf_we_o,
  output logic [FP_REG_ADDR_W-1:0] rf_waddr_o,
  output logic [DataWidth-1:0]     rf_wdata_o,

  input  logic                     issue_valid_i,
  input  logic [FP_REG_ADDR_W-1:0] issue_waddr_i,

  input  logic [FP_REG_ADDR_W-1:0] raddr_a_i,
  input  logic [FP_REG_ADDR_W-1:0] raddr_b_i,
  output logic                     hazard_a_o,
  output logic                     hazard_b_o,
  output logic                     hazard_w_o,

  input  logic                     flush_i
);

  fp_wb_src_e               r_last_gnt;
  logic                     r_rf_we;
  logic [FP_REG_ADDR_W-1:0] r_rf_waddr;
  logic [DataWidth-1:0]     r_rf_wdata;

  logic                     w_fpu_gnt;
  logic                     w_lsu_gnt;

  // A lone requester wins outright; on a tie the side that did not win the
  // last transfer goes first. Grants look only at valids and the last-grant
  // state, never at the requesters' address or data.
  assign w_fpu_gnt = fpu_valid_i & (~lsu_valid_i | (r_last_gnt == FP_WB_LSU));
  assign w_lsu_gnt = lsu_valid_i & (~fpu_valid_i | (r_last_gnt == FP_WB_FPU));

  assign fpu_ready_o = w_fpu_gnt;
  assign lsu_ready_o = w_lsu_gnt;

  // Reset to LSU so the first tie after reset is awarded to the FPU.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_gnt <= FP_WB_LSU;
    end else if (w_fpu_gnt) begin
      r_last_gnt <= FP_WB_FPU;
    end else if (w_lsu_gnt) begin
      r_last_gnt <= FP_WB_LSU;
    end
  end

  // Write-enable is a one-cycle pulse per transfer; address and data hold
  // their last value while idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we <= w_fpu_gnt | w_lsu_gnt;
      if (w_fpu_gnt) begin
        r_rf_waddr <= fpu_waddr_i;
        r_rf_wdata <= fpu_wdata_i;
      end else if (w_lsu_gnt) begin
        r_rf_waddr <= lsu_waddr_i;
        r_rf_wdata <= lsu_wdata_i;
      end
    end
  end

  assign rf_we_o    = r_rf_we;
  assign rf_waddr_o = r_rf_waddr;
  assign rf_wdata_o = r_rf_wdata;

`ifdef IBEX_FPU_SCOREBOARD_EN
  // The pending bit clears on the edge that ends the cycle in which the
  // register file is actually written, i.e. from the registered write port.
  ibex_fpu_scoreboard u_scoreboard (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .issue_valid_i (issue_valid_i),
    .issue_waddr_i (issue_waddr_i),
    .flush_i       (flush_i),
    .wb_valid_i    (r_rf_we),
    .wb_waddr_i    (r_rf_waddr),
    .raddr_a_i     (raddr_a_i),
    .raddr_b_i     (raddr_b_i),
    .hazard_a_o    (hazard_a_o),
    .hazard_b_o    (hazard_b_o),
    .hazard_w_o    (hazard_w_o)
  );
`else
  logic w_unused;

  assign w_unused   = ^{issue_valid_i, issue_waddr_i, flush_i, raddr_a_i, raddr_b_i};
  assign hazard_a_o = 1'b0;
  assign hazard_b_o = 1'b0;
  assign hazard_w_o = 1'b0;
`endif

endmodule : ibex_fpu_wb_arbiter
`default_nettype wire

// File: tb/tb_ibex_fpu_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_fpu_wb_arbiter
// Description : Directed self-checking bench for ibex_fpu_wb_arbiter.
//               Hazard expectations are gated by IBEX_FPU_SCOREBOARD_EN so
//               the same bench covers both builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_fpu_wb_arbiter;

`ifdef IBEX_FPU_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_ni;
  logic        fpu_valid, fpu_ready, lsu_valid, lsu_ready;
  logic [4:0]  fpu_waddr, lsu_waddr;
  logic [31:0] fpu_wdata, lsu_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        issue_valid;
  logic [4:0]  issue_waddr, raddr_a, raddr_b;
  logic        hazard_a, hazard_b, hazard_w;
  logic        flush;

  int n_vec = 0;
  int n_err = 0;

  ibex_fpu_wb_arbiter #(.DataWidth(32)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .fpu_valid_i   (fpu_valid),
    .fpu_ready_o   (fpu_ready),
    .fpu_waddr_i   (fpu_waddr),
    .fpu_wdata_i   (fpu_wdata),
    .lsu_valid_i   (lsu_valid),
    .lsu_ready_o   (lsu_ready),
    .lsu_waddr_i   (lsu_waddr),
    .lsu_wdata_i   (lsu_wdata),
    .rf_we_o       (rf_we),
    .rf_waddr_o    (rf_waddr),
    .rf_wdata_o    (rf_wdata),
    .issue_valid_i (issue_valid),
    .issue_waddr_i (issue_waddr),
    .raddr_a_i     (raddr_a),
    .raddr_b_i     (raddr_b),
    .hazard_a_o    (hazard_a),
    .hazard_b_o    (hazard_b),
    .hazard_w_o    (hazard_w),
    .flush_i       (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs are checked 1 time unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fpu_valid = 0; fpu_waddr = 0; fpu_wdata = 0;
    lsu_valid = 0; lsu_waddr = 0; lsu_wdata = 0;
    issue_valid = 0; issue_waddr = 0; raddr_a = 0; raddr_b = 0; flush = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_ni = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    // Dirty the state first so the reset has something to clear.
    next_cycle();
    fpu_valid = 1; fpu_waddr = 5'd17; fpu_wdata = 32'hDEADBEEF;
    issue_valid = 1; issue_waddr = 5'd17; raddr_a = 5'd17; raddr_b = 5'd17;
    next_cycle();
    clear_inputs();
    raddr_a = 5'd17; raddr_b = 5'd17; issue_waddr = 5'd17;
    #1 rst_ni = 0;
    #1;
    n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_we got=%0b exp=0", rf_we); end
    n_vec++; if (rf_waddr !== 5'd0) begin n_err++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
    n_vec++; if (rf_wdata !== 32'h0) begin n_err++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
    n_vec++; if ({hazard_a, hazard_b, hazard_w} !== 3'b000) begin
      n_err++; $display("FAIL reset_hazards got=%b exp=000", {hazard_a, hazard_b, hazard_w}); end
    n_vec++; if ({fpu_ready, lsu_ready} !== 2'b00) begin
      n_err++; $display("FAIL reset_idle_ready got=%b exp=00", {fpu_ready, lsu_ready}); end
    @(posedge clk);
    @(posedge clk);
    #1 rst_ni = 1;
  endtask

  task automatic test_single_fpu();
    do_reset();
    fpu_valid = 1; fpu_waddr = 5'd3; fpu_wdata = 32'h3F800000;
    #1;
    n_vec++; if ({fpu_ready, lsu_ready} !== 2'b10) begin
      n_err++; $display("FAIL fpu_alone_ready got=%b exp=10", {fpu_ready, lsu_ready}); end
    next_cycle();
    fpu_valid = 0;
    #1;
    n_vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h3F800000}) begin
      n_err++; $display("FAIL fpu_alone_wb got=%b/%0d/%h exp=1/3/3f800000", rf_we, rf_waddr, rf_wdata); end
    next_cycle();
    #1;
    n_vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd3, 32'h3F800000}) begin
      n_err++; $display("FAIL fpu_alone_hold got=%b/%0d/%h exp=0/3/3f800000", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_single_lsu();
    // Last grant is FPU here; a lone LSU must still win immediately, and
    // register index 0 is an ordinary destination.
    lsu_valid = 1; lsu_waddr = 5'd0; lsu_wdata = 32'h12345678;
    #1;
    n_vec++; if ({fpu_ready, lsu_ready} !== 2'b01) begin
      n_err++; $display("FAIL lsu_alone_ready got=%b exp=01", {fpu_ready, lsu_ready}); end
    next_cycle();
    lsu_valid = 0;
    #1;
    n_vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd0, 32'h12345678}) begin
      n_err++; $display("FAIL lsu_f0_wb got=%b/%0d/%h exp=1/0/12345678", rf_we, rf_waddr, rf_wdata); end
    next_cycle();
    #1;
    n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL lsu_we_drop got=%b exp=0", rf_we); end
  endtask

  task automatic test_back_to_back();
    // Expected transfer order after reset: F0(f10) L0(f20) F1(f11) L1(f21).
    logic [4:0]  exp_a [4] = '{5'd10, 5'd20, 5'd11, 5'd21};
    logic [31:0] exp_d [4] = '{32'hF0000000, 32'hA0000000, 32'hF0000001, 32'hA0000001};
    logic [1:0]  exp_rdy [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    int fi = 0;
    int li = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      fpu_valid = 1; fpu_waddr = 5'(10 + fi); fpu_wdata = 32'hF0000000 + 32'(fi);
      lsu_valid = 1; lsu_waddr = 5'(20 + li); lsu_wdata = 32'hA0000000 + 32'(li);
      #1;
      n_vec++; if ({fpu_ready, lsu_ready} !== exp_rdy[k]) begin
        n_err++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, {fpu_ready, lsu_ready}, exp_rdy[k]); end
      if (k > 0) begin
        n_vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, exp_a[k-1], exp_d[k-1]}) begin
          n_err++; $display("FAIL rr_wb[%0d] got=%b/%0d/%h exp=1/%0d/%h",
                            k - 1, rf_we, rf_waddr, rf_wdata, exp_a[k-1], exp_d[k-1]); end
      end
      if (exp_rdy[k][1]) fi++; else li++;
      next_cycle();
    end
    fpu_valid = 0; lsu_valid = 0;
    #1;
    n_vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, exp_a[3], exp_d[3]}) begin
      n_err++; $display("FAIL rr_wb[3] got=%b/%0d/%h exp=1/%0d/%h", rf_we, rf_waddr, rf_wdata, exp_a[3], exp_d[3]); end
    next_cycle();
    #1;
    n_vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, exp_a[3], exp_d[3]}) begin
      n_err++; $display("FAIL rr_idle got=%b/%0d/%h exp=0/%0d/%h", rf_we, rf_waddr, rf_wdata, exp_a[3], exp_d[3]); end
  endtask

  task automatic test_raw_hazard();
    logic [4:0] exp_haz;
    do_reset();
    raddr_a = 5'd5; raddr_b = 5'd6;
    // cycle 0: reserve f5
    issue_valid = 1; issue_waddr = 5'd5;
    #1;
    n_vec++; if (hazard_a !== 1'b0) begin n_err++; $display("FAIL raw_c0 got=%b exp=0", hazard_a); end
    // cycles 1..4; FPU writes f5 in cycle 2, RF write visible in cycle 3
    exp_haz = {1'b0, SB_EN, SB_EN, SB_EN, 1'b0};
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      issue_valid = 0; issue_waddr = 5'd30;
      fpu_valid = (c == 2); fpu_waddr = 5'd5; fpu_wdata = 32'h40000000;
      #1;
      n_vec++; if (hazard_a !== exp_haz[c]) begin
        n_err++; $display("FAIL raw_c%0d got=%b exp=%b", c, hazard_a, exp_haz[c]); end
      if (c == 3) begin
        n_vec++; if ({rf_we, rf_waddr, hazard_b} !== {1'b1, 5'd5, 1'b0}) begin
          n_err++; $display("FAIL raw_wb got=%b/%0d/%b exp=1/5/0", rf_we, rf_waddr, hazard_b); end
      end
    end
    fpu_valid = 0;
  endtask

  task automatic test_set_wins();
    do_reset();
    issue_valid = 1; issue_waddr = 5'd7;
    next_cycle();
    issue_valid = 0;
    fpu_valid = 1; fpu_waddr = 5'd7; fpu_wdata = 32'h00000777;
    next_cycle();
    // rf_we=1 to f7 in this cycle; re-reserve f7 on the same edge.
    fpu_valid = 0; issue_valid = 1; issue_waddr = 5'd7;
    #1;
    n_vec++; if ({rf_we, rf_waddr, hazard_w} !== {1'b1, 5'd7, SB_EN}) begin
      n_err++; $display("FAIL setwin_pre got=%b/%0d/%b exp=1/7/%b", rf_we, rf_waddr, hazard_w, SB_EN); end
    next_cycle();
    issue_valid = 0;
    #1;
    n_vec++; if (hazard_w !== SB_EN) begin
      n_err++; $display("FAIL setwin_post got=%b exp=%b", hazard_w, SB_EN); end
  endtask

  task automatic test_flush();
    // f7 is still pending from the previous task and must be flushed too.
    issue_valid = 1; issue_waddr = 5'd1;
    next_cycle();
    issue_waddr = 5'd2;
    next_cycle();
    raddr_a = 5'd1; raddr_b = 5'd2;
    #1;
    n_vec++; if ({hazard_a, hazard_b} !== {SB_EN, SB_EN}) begin
      n_err++; $display("FAIL flush_pre got=%b exp=%b", {hazard_a, hazard_b}, {SB_EN, SB_EN}); end
    flush = 1; issue_waddr = 5'd9;
    next_cycle();
    flush = 0; issue_valid = 0;
    #1;
    n_vec++; if ({hazard_a, hazard_b, hazard_w} !== {1'b0, 1'b0, SB_EN}) begin
      n_err++; $display("FAIL flush_post got=%b exp=00%b", {hazard_a, hazard_b, hazard_w}, SB_EN); end
    raddr_a = 5'd7;
    #1;
    n_vec++; if (hazard_a !== 1'b0) begin n_err++; $display("FAIL flush_f7 got=%b exp=0", hazard_a); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    raddr_a = 5'd4; raddr_b = 5'd4;
    issue_valid = 1; issue_waddr = 5'd4;
    next_cycle();
    issue_valid = 0;
    fpu_valid = 1; fpu_waddr = 5'd4; fpu_wdata = 32'h55555555;
    #1;
    n_vec++; if ({fpu_ready, hazard_a} !== {1'b1, SB_EN}) begin
      n_err++; $display("FAIL rstmid_pre got=%b exp=1%b", {fpu_ready, hazard_a}, SB_EN); end
    #1 rst_ni = 0;
    #1;
    n_vec++; if ({rf_we, hazard_a, hazard_b, hazard_w} !== 4'b0000) begin
      n_err++; $display("FAIL rstmid_in got=%b exp=0000", {rf_we, hazard_a, hazard_b, hazard_w}); end
    next_cycle();
    fpu_valid = 0;
    rst_ni = 1;
    #1;
    n_vec++; if ({rf_we, hazard_a, hazard_b, hazard_w} !== 4'b0000) begin
      n_err++; $display("FAIL rstmid_rel got=%b exp=0000", {rf_we, hazard_a, hazard_b, hazard_w}); end
    next_cycle();
    #1;
    n_vec++; if ({rf_we, hazard_a} !== 2'b00) begin
      n_err++; $display("FAIL rstmid_after got=%b exp=00", {rf_we, hazard_a}); end
  endtask

  initial begin
    rst_ni = 1;
    clear_inputs();
    test_reset();
    test_single_fpu();
    test_single_lsu();
    test_back_to_back();
    test_raw_hazard();
    test_set_wins();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ibex_fpu_wb_arbiter
`default_nettype wire
